// File: rtl/pc_sequencer.sv
// Fetch/issue sequencer driving PC select, imem handshake and the instruction register.
// Latency: one IDLE cycle, then >=1 FETCH cycle per instruction plus one ISSUE cycle; stall freezes ISSUE.
module pc_sequencer #(
   parameter logic [31:0] IRQ_VECTOR  = 32'h00060100,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_cur,
   output logic [1:0]  ps,
   output logic [31:0] pc_in,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        ir_valid,
   output logic [31:0] ir_data,
   output logic [31:0] ir_pc,
   input  logic        stall,
   input  logic        jmp_take,
   input  logic [31:0] jmp_target,
   input  logic        br_take,
   input  logic [31:0] br_off,
   input  logic        eret,
   input  logic        irq,
   output logic        irq_ack,
   output logic [31:0] epc,
   input  logic        halt_req,
   input  logic        resume,
   output logic        halted,
   output logic        fetch_err
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALT} state_t;

   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state, state_nxt;
   logic [7:0] tcnt;
   logic       isr_active;
   logic       capture, timeout, retire, take_irq, take_eret;

   assign imem_req = (state == S_FETCH);
   assign halted   = (state == S_HALT);

   always_comb begin
      state_nxt = state;
      ps        = 2'b00;
      pc_in     = '0;
      capture   = 1'b0;
      timeout   = 1'b0;
      retire    = 1'b0;
      take_irq  = 1'b0;
      take_eret = 1'b0;
      case (state)
         S_IDLE: state_nxt = S_FETCH;
         S_FETCH: begin
            if (imem_ack) begin
               capture   = 1'b1;
               state_nxt = S_ISSUE;
            end else if (tcnt == TMO_LAST) begin
               timeout   = 1'b1;
               state_nxt = S_HALT;
            end
         end
         S_ISSUE: begin
            // The only state allowed to move the PC, and only when downstream accepts.
            if (!stall) begin
               retire    = 1'b1;
               state_nxt = S_FETCH;
               if (irq && !isr_active) begin
                  take_irq = 1'b1;
                  ps       = 2'b10;
                  pc_in    = IRQ_VECTOR;
               end else if (eret) begin
                  take_eret = 1'b1;
                  ps        = 2'b10;
                  pc_in     = epc;
               end else if (jmp_take) begin
                  ps    = 2'b10;
                  pc_in = jmp_target;
               end else if (br_take) begin
                  ps    = 2'b11;
                  pc_in = br_off;
               end else begin
                  ps = 2'b01;
                  if (halt_req) state_nxt = S_HALT;
               end
            end
         end
         S_HALT: if (resume) state_nxt = S_FETCH;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         tcnt       <= '0;
         isr_active <= 1'b0;
         ir_valid   <= 1'b0;
         ir_data    <= '0;
         ir_pc      <= '0;
         epc        <= '0;
         irq_ack    <= 1'b0;
         fetch_err  <= 1'b0;
      end else begin
         state   <= state_nxt;
         irq_ack <= take_irq;
         if (state == S_FETCH) tcnt <= (capture || timeout) ? 8'd0 : tcnt + 8'd1;
         if (capture) begin
            ir_data  <= imem_rdata;
            ir_pc    <= pc_cur;
            ir_valid <= 1'b1;
         end
         if (retire) ir_valid <= 1'b0;
         if (timeout) fetch_err <= 1'b1;
         else if (state == S_HALT && resume) fetch_err <= 1'b0;
         if (take_irq) begin
            epc        <= pc_cur + 32'd4;
            isr_active <= 1'b1;
         end else if (take_eret) begin
            isr_active <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: models the PC register, scoreboards fetched words against ir_pc/ir_data.
module tb_pc_sequencer;

   localparam logic [31:0] ROM_BASE = 32'h00060000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_cur;
   logic [1:0]  ps;
   logic [31:0] pc_in;
   logic        imem_req, imem_ack;
   logic [31:0] imem_rdata;
   logic        ir_valid;
   logic [31:0] ir_data, ir_pc;
   logic        stall, jmp_take, br_take, eret, irq;
   logic [31:0] jmp_target, br_off;
   logic        irq_ack;
   logic [31:0] epc;
   logic        halt_req, resume, halted, fetch_err;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   logic prev_v = 1'b0;

   pc_sequencer #(.IRQ_VECTOR(32'h00060100), .MEM_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .pc_cur(pc_cur), .ps(ps), .pc_in(pc_in),
      .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc),
      .stall(stall), .jmp_take(jmp_take), .jmp_target(jmp_target),
      .br_take(br_take), .br_off(br_off), .eret(eret), .irq(irq),
      .irq_ack(irq_ack), .epc(epc), .halt_req(halt_req), .resume(resume),
      .halted(halted), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   // PC register environment
   always @(posedge clk) begin
      if (rst) pc_cur <= ROM_BASE;
      else case (ps)
         2'b01:   pc_cur <= pc_cur + 32'd4;
         2'b10:   pc_cur <= pc_in;
         2'b11:   pc_cur <= pc_cur + {pc_in[29:0], 2'b00};
         default: pc_cur <= pc_cur;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (ir_valid && !prev_v) begin
         if (sb.size() == 0) chk("sb_extra", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            chk("sb_ir_pc", ir_pc, e.pc);
            chk("sb_ir_data", ir_data, e.data);
         end
      end
      prev_v = ir_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called in a FETCH cycle; acks after 'waits' extra cycles, returns in ISSUE.
   task automatic fetch(input int waits, input logic [31:0] data);
      repeat (waits) tick();
      imem_ack   = 1'b1;
      imem_rdata = data;
      sb.push_back({pc_cur, data});
      tick();
      imem_ack   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; imem_ack = 0; imem_rdata = 0; stall = 0; jmp_take = 0; jmp_target = 0;
      br_take = 0; br_off = 0; eret = 0; irq = 0; halt_req = 0; resume = 0;
      repeat (3) tick();
      chk("rst_ir_valid", ir_valid, 0);
      chk("rst_ir_data", ir_data, 0);
      chk("rst_ir_pc", ir_pc, 0);
      chk("rst_epc", epc, 0);
      chk("rst_irq_ack", irq_ack, 0);
      chk("rst_fetch_err", fetch_err, 0);
      chk("rst_halted", halted, 0);
      chk("rst_imem_req", imem_req, 0);
      chk("rst_ps", ps, 0);
      rst = 1'b0;

      // First fetch, ack in 2nd FETCH cycle
      tick();
      chk("f1_req", imem_req, 1);
      chk("f1_ps", ps, 0);
      chk("f1_pc", pc_cur, 32'h00060000);
      fetch(1, 32'h11111111);
      #1;
      chk("iss1_valid", ir_valid, 1);
      chk("iss1_ps", ps, 2'b01);
      tick();
      chk("seq_pc", pc_cur, 32'h00060004);
      chk("seq_valid", ir_valid, 0);

      // Jump beats branch, then branch alone with negative offset
      fetch(0, 32'h22222222);
      tick();
      fetch(0, 32'h33333333);
      chk("br_pc_at", pc_cur, 32'h00060008);
      jmp_take = 1; jmp_target = 32'h00060040; br_take = 1; br_off = 32'hFFFFFFFE;
      #1;
      chk("jmp_ps", ps, 2'b10);
      chk("jmp_pc_in", pc_in, 32'h00060040);
      jmp_take = 0;
      #1;
      chk("br_ps", ps, 2'b11);
      chk("br_pc_in", pc_in, 32'hFFFFFFFE);
      tick();
      br_take = 0;
      chk("br_next_pc", pc_cur, 32'h00060000);

      // Interrupt, masking, eret
      fetch(0, 32'h44444444);
      jmp_take = 1; jmp_target = 32'h00060010;
      tick();
      jmp_take = 0;
      fetch(0, 32'h55555555);
      irq = 1; halt_req = 1;
      #1;
      chk("irq_ps", ps, 2'b10);
      chk("irq_pc_in", pc_in, 32'h00060100);
      chk("irq_ack_pre", irq_ack, 0);
      tick();
      halt_req = 0;
      chk("irq_no_halt", halted, 0);
      chk("irq_ack_pulse", irq_ack, 1);
      chk("irq_epc", epc, 32'h00060014);
      chk("irq_vec_pc", pc_cur, 32'h00060100);
      tick();
      chk("irq_ack_once", irq_ack, 0);
      fetch(0, 32'h66666666);
      #1;
      chk("irq_masked_ps", ps, 2'b01);
      tick();
      chk("irq_ack_masked", irq_ack, 0);
      fetch(0, 32'h77777777);
      eret = 1;
      #1;
      chk("eret_ps", ps, 2'b10);
      chk("eret_pc_in", pc_in, 32'h00060014);
      tick();
      eret = 0;
      chk("eret_pc", pc_cur, 32'h00060014);
      fetch(0, 32'h88888888);
      #1;
      chk("irq_retake_ps", ps, 2'b10);
      chk("irq_retake_pc_in", pc_in, 32'h00060100);
      tick();
      irq = 0;
      chk("irq_retake_epc", epc, 32'h00060018);
      chk("irq_retake_ack", irq_ack, 1);
      fetch(0, 32'h99999999);
      eret = 1;
      #1;
      chk("eret2_pc_in", pc_in, 32'h00060018);
      tick();
      eret = 0;

      // Stall holds ISSUE
      fetch(0, 32'hCAFEF00D);
      stall = 1; br_take = 1; br_off = 32'd4; jmp_take = 1; jmp_target = 32'h00000BAD;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_ps", ps, 0);
         chk("stall_valid", ir_valid, 1);
         chk("stall_data", ir_data, 32'hCAFEF00D);
         chk("stall_pc", ir_pc, 32'h00060018);
         tick();
      end
      jmp_take = 0;
      stall = 0;
      #1;
      chk("unstall_ps", ps, 2'b11);
      chk("unstall_pc_in", pc_in, 32'd4);
      tick();
      br_take = 0;
      chk("unstall_pc", pc_cur, 32'h00060028);

      // Fetch timeout
      repeat (15) tick();
      chk("tmo_not_early", imem_req, 1);
      chk("tmo_err_early", fetch_err, 0);
      tick();
      chk("tmo_halted", halted, 1);
      chk("tmo_err", fetch_err, 1);
      chk("tmo_req", imem_req, 0);
      chk("tmo_ps", ps, 0);
      chk("tmo_pc", pc_cur, 32'h00060028);
      irq = 1;
      tick();
      chk("halt_irq_ack", irq_ack, 0);
      chk("halt_irq_stay", halted, 1);
      irq = 0; resume = 1;
      tick();
      resume = 0;
      chk("resume_err", fetch_err, 0);
      chk("resume_req", imem_req, 1);
      chk("resume_pc", pc_cur, 32'h00060028);

      // halt_req
      fetch(0, 32'hABCD0001);
      halt_req = 1;
      #1;
      chk("hreq_ps", ps, 2'b01);
      tick();
      halt_req = 0;
      chk("hreq_halted", halted, 1);
      chk("hreq_pc", pc_cur, 32'h0006002C);
      resume = 1;
      tick();
      resume = 0;
      chk("hreq_resume", imem_req, 1);

      // Reset mid-fetch, late ack ignored
      rst = 1;
      tick();
      rst = 0; imem_ack = 1; imem_rdata = 32'hDEADBEEF;
      #1;
      chk("mrst_req", imem_req, 0);
      chk("mrst_valid", ir_valid, 0);
      tick();
      imem_ack = 0;
      chk("mrst_ack_ignored", ir_valid, 0);
      chk("mrst_data", ir_data, 0);
      chk("mrst_fetch", imem_req, 1);
      fetch(0, 32'h5A5A5A5A);
      chk("post_rst_valid", ir_valid, 1);
      tick();
      chk("sb_drain", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Control FSM that drives the program counter's 2-bit select (ps) and target/offset input (pc_in) every cycle.
- Owns the instruction-fetch handshake to instruction memory and presents the fetched word to decode.
- Chooses the next PC from, in priority order: interrupt, exception return, jump, branch, sequential.
- Sits between the PC register, the imem port and the decode/execute stages. The PC register itself resets to ROM_BASE.

Parameters:
IRQ_VECTOR, 32'h00060100, absolute address loaded into the PC when an interrupt is taken
MEM_TIMEOUT, 16, number of FETCH cycles without imem_ack before a fetch error is declared (legal range 2..255)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
pc_cur  in  32  current PC register output
ps  out  2  PC select: 00 hold, 01 PC+4, 10 load pc_in, 11 PC + (pc_in<<2)
pc_in  out  32  jump target / word branch offset to the PC
imem_req  out  1  fetch request; address is pc_cur
imem_ack  in  1  fetch data valid on imem_rdata this cycle
imem_rdata  in  32  fetched instruction word
ir_valid  out  1  ir_data/ir_pc hold a valid instruction
ir_data  out  32  registered instruction
ir_pc  out  32  address of ir_data
stall  in  1  downstream not ready; freezes ISSUE
jmp_take  in  1  absolute jump request, sampled in ISSUE
jmp_target  in  32  jump address
br_take  in  1  taken branch, sampled in ISSUE
br_off  in  32  signed word offset
eret  in  1  return from interrupt, sampled in ISSUE
irq  in  1  level interrupt request
irq_ack  out  1  one-cycle pulse when an interrupt is taken
epc  out  32  saved return address
halt_req  in  1  stop after the current instruction
resume  in  1  leave HALT
halted  out  1  high in HALT
fetch_err  out  1  sticky imem timeout flag

Behaviour:
- Combinational defaults: ps=00 and pc_in=0 in every state unless a rule below says otherwise.
- Reset (rst=1 at an edge):
  - state=IDLE.
  - ir_valid, ir_data, ir_pc, epc, irq_ack, fetch_err, isr_active and the timeout counter all go to 0.
  - halted=0, imem_req=0.
- IDLE: lasts one cycle, then FETCH.
- FETCH:
  - imem_req=1, ps=00, ir_valid=0; the timeout counter increments each cycle.
  - If imem_ack=1 (which may arrive in the first FETCH cycle), at the edge: ir_data<=imem_rdata, ir_pc<=pc_cur, ir_valid<=1, counter<=0, and the state goes to ISSUE.
  - If the counter reaches MEM_TIMEOUT-1 with no ack: fetch_err<=1 and the state goes to HALT; the PC is held.
- ISSUE, with stall=1: ps=00, state and ir_* are held, and every request input is ignored.
- ISSUE, with stall=0: exactly one action is taken, by first match below; in every case ir_valid<=0 at the edge.
  1. irq && !isr_active: ps=10, pc_in=IRQ_VECTOR, epc<=pc_cur+4, isr_active<=1, irq_ack=1 for the following cycle; next state FETCH.
  2. eret: ps=10, pc_in=epc, isr_active<=0; next state FETCH.
  3. jmp_take: ps=10, pc_in=jmp_target; next state FETCH.
  4. br_take: ps=11, pc_in=br_off; next state FETCH.
  5. Otherwise ps=01; next state is HALT if halt_req=1, else FETCH.
- Interrupt vs halt: an interrupt taken in ISSUE overrides halt_req. halt_req is re-evaluated at the next ISSUE.
- HALT:
  - ps=00, halted=1, imem_req=0.
  - resume=1 clears fetch_err and moves to FETCH on the next edge.
  - irq is ignored in HALT.
- Branch arithmetic: br_off is a two's-complement word offset. The PC computes pc_cur + {br_off[29:0],2'b00} modulo 2^32; wrap-around is legal and not flagged.
- isr_active:
  - Masks irq, so only one interrupt level is supported.
  - eret while isr_active=0 still redirects to epc.
- No PC change while imem_req is high: ps is non-zero only in the ISSUE cycle that ends an instruction.
- Reset takes precedence over every input in any state, including mid-fetch. A late imem_ack after reset is ignored because the FSM is in IDLE.

Test Plan:
- Reset, then imem_ack on the 2nd FETCH cycle with rdata=0x11111111, pc_cur=0x00060000 → ir_pc=0x00060000, ir_data=0x11111111, ir_valid=1 for one ISSUE cycle with ps=01; next fetch address 0x00060004.
- In ISSUE: br_take=1, br_off=-2 (0xFFFFFFFE), pc_cur=0x00060008 → ps=11, pc_in=0xFFFFFFFE, next PC 0x00060000. Same ISSUE cycle with jmp_take=1 also asserted → jump wins: ps=10, pc_in=jmp_target.
- irq=1 during ISSUE at pc_cur=0x00060010 → ps=10, pc_in=0x00060100, epc=0x00060014, irq_ack pulses once; irq still high at the next ISSUE → not re-taken, ps=01. eret → pc_in=0x00060014, isr_active cleared.
- stall=1 held 3 cycles in ISSUE with br_take=1 → ps=00 and ir_* unchanged for all 3 cycles; stall drops → ps=11 in that cycle.
- No imem_ack for MEM_TIMEOUT=16 FETCH cycles → fetch_err=1 and halted=1 after the 16th cycle, PC unchanged; resume=1 → fetch_err=0, back in FETCH at the same address.
- halt_req=1 in an unstalled ISSUE → ps=01, then HALT with halted=1. rst pulsed mid-FETCH with imem_ack arriving one cycle later → state IDLE, ir_valid=0, the ack is ignored.
